// File: rtl/result_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : result_uart_reporter
//  Description : Result path of the serial GA loop. When the upstream
//                chromosome FSM raises iDoneProcessing, the eight per-bit
//                error sums are captured into a shadow register and sent to
//                the host as one framed 8N1 UART packet:
//                  header, sums[0..7] little-endian, [total], XOR checksum.
//                When the last stop bit has been sent, a one-cycle ack is
//                returned upstream and the completed-frame counter advances.
//  Options     : RESULT_TX_TOTAL_EN - when defined, the 32-bit sum of all
//                eight error sums (little-endian) is inserted ahead of the
//                checksum, the frame grows to 38 bytes and the header
//                becomes 8'hA6. When undefined, the frame is 34 bytes and
//                no adder is built.
//  Parameters  : CLKS_PER_BIT - clock cycles per UART bit (>= 2)
//                HEADER_BYTE  - first byte of every frame
//  Ports       : iClock                  in  clock, rising edge
//                iReset                  in  asynchronous reset, active-high
//                iDoneProcessing         in  upstream done level
//                iErrorSums[7:0][31:0]   in  upstream error sums
//                oDoneProcessingFeedback out one-cycle ack to upstream
//                oTx                     out UART TX line, idle high
//                oBusy                   out high from latch until ack issued
//                oFramesSent[15:0]       out completed-frame counter (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module result_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 434,
`ifdef RESULT_TX_TOTAL_EN
    parameter logic [7:0]  HEADER_BYTE  = 8'hA6
`else
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
`endif
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iDoneProcessing,
    input  logic [7:0][31:0] iErrorSums,
    output logic             oDoneProcessingFeedback,
    output logic             oTx,
    output logic             oBusy,
    output logic [15:0]      oFramesSent
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    // Last count of a full bit period.
    localparam logic [TW-1:0] C_CNT_LAST = TW'(CLKS_PER_BIT - 1);
    // The stop state owns all but the final stop-bit cycle; NEXT_BYTE
    // supplies that final cycle so consecutive bytes stay back-to-back.
    localparam logic [TW-1:0] C_CNT_STOP = TW'(CLKS_PER_BIT - 2);

`ifdef RESULT_TX_TOTAL_EN
    localparam logic [5:0] C_LAST_IDX = 6'd37;
`else
    localparam logic [5:0] C_LAST_IDX = 6'd33;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_NEXT_BYTE = 3'd4,
        S_ACK       = 3'd5,
        S_RELEASE   = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [TW-1:0]     cnt_q,      cnt_d;
    logic [2:0]        bit_idx_q,  bit_idx_d;
    logic [5:0]        byte_idx_q, byte_idx_d;
    logic [7:0][31:0]  sums_q,     sums_d;
    logic [7:0]        shreg_q,    shreg_d;
    logic [7:0]        checksum_q, checksum_d;
    logic              tx_q,       tx_d;
    logic              busy_q,     busy_d;
    logic              ack_q,      ack_d;
    logic [15:0]       frames_q,   frames_d;

    // ------------------------------------------------------------------------
    // Frame byte selection
    // ------------------------------------------------------------------------
    logic [255:0] w_sums_flat;
    logic [4:0]   w_sum_off;
    logic [7:0]   w_byte;

    // Byte k (0..31) of the flattened shadow is sums[k/4] byte k%4, which is
    // exactly the little-endian order the frame wants.
    assign w_sums_flat = sums_q;
    assign w_sum_off   = byte_idx_q[4:0] - 5'd1;

`ifdef RESULT_TX_TOTAL_EN
    logic [31:0] w_total;
    logic [1:0]  w_tot_off;

    // Frame bytes 33..36 map to total bytes 0..3.
    assign w_tot_off = byte_idx_q[1:0] - 2'd1;

    always_comb begin
        w_total = 32'd0;
        for (int i = 0; i < 8; i++) begin
            w_total = w_total + sums_q[i];
        end
    end

    always_comb begin
        w_byte = checksum_q;
        if (byte_idx_q == 6'd0) begin
            w_byte = HEADER_BYTE;
        end else if (byte_idx_q <= 6'd32) begin
            w_byte = w_sums_flat[{w_sum_off, 3'b000} +: 8];
        end else if (byte_idx_q <= 6'd36) begin
            w_byte = w_total[{w_tot_off, 3'b000} +: 8];
        end
    end
`else
    always_comb begin
        w_byte = checksum_q;
        if (byte_idx_q == 6'd0) begin
            w_byte = HEADER_BYTE;
        end else if (byte_idx_q <= 6'd32) begin
            w_byte = w_sums_flat[{w_sum_off, 3'b000} +: 8];
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        sums_d     = sums_q;
        shreg_d    = shreg_q;
        checksum_d = checksum_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        frames_d   = frames_q;
        tx_d       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (iDoneProcessing) begin
                    sums_d     = iErrorSums;
                    busy_d     = 1'b1;
                    byte_idx_d = 6'd0;
                    checksum_d = 8'd0;
                    cnt_d      = '0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    shreg_d   = w_byte;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == C_CNT_STOP) begin
                    cnt_d   = '0;
                    state_d = S_NEXT_BYTE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Final stop-bit cycle: fold the byte just sent into the running
            // checksum and either chain the next start bit or finish.
            S_NEXT_BYTE: begin
                checksum_d = checksum_q ^ w_byte;
                if (byte_idx_q == C_LAST_IDX) begin
                    ack_d    = 1'b1;
                    frames_d = frames_q + 16'd1;
                    state_d  = S_ACK;
                end else begin
                    byte_idx_d = byte_idx_q + 6'd1;
                    state_d    = S_START;
                end
            end

            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_RELEASE;
            end

            // Holding here until done falls keeps one done level from
            // launching a second frame.
            S_RELEASE: begin
                if (!iDoneProcessing) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // TX is registered from the upcoming state so the line is glitch-free.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 6'd0;
            sums_q     <= '0;
            shreg_q    <= 8'd0;
            checksum_q <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            frames_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            sums_q     <= sums_d;
            shreg_q    <= shreg_d;
            checksum_q <= checksum_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            frames_q   <= frames_d;
        end
    end

    assign oTx                     = tx_q;
    assign oBusy                   = busy_q;
    assign oDoneProcessingFeedback = ack_q;
    assign oFramesSent             = frames_q;

endmodule
`default_nettype wire
